// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter for the 34-entry register file (GPRs 0-31, $hi 32, $lo 33).
// The pipeline MEM/WB stream has priority. Mult/div results wait in a one-entry
// buffer. A starvation FSM freezes WB for one cycle so a blocked result can drain.
// In-flight mult/div operations are counted to raise a hi/lo hazard toward decode.
module regfile_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned MAX_OUT      = 2,
  parameter int unsigned CNT_W        = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_wb_regwrite,
  input  logic [5:0]  i_wb_rd,
  input  logic [31:0] i_wb_data,
  input  logic        i_md_issue,
  output logic        o_md_issue_ready,
  input  logic        i_md_valid,
  input  logic [63:0] i_md_prod,
  output logic        o_md_ready,
  input  logic        i_id_uses_hilo,
  output logic        o_hilo_hazard,
  output logic        o_wb_freeze,
  output logic        o_rf_we,
  output logic [5:0]  o_rf_waddr,
  output logic [31:0] o_rf_wdata,
  output logic [63:0] o_rf_prod,
  output logic        o_wb_err
);

  localparam int unsigned StW      = $clog2(STARVE_LIMIT + 1);
  localparam logic [5:0]  PairAddr = 6'd34;
  localparam logic [5:0]  LastReg  = 6'd33;

  typedef enum logic [1:0] {StIdle, StHeld, StForce} state_e;

  state_e           r_state, w_state_d;
  logic [StW-1:0]   r_starve, w_starve_d, w_starve_inc;
  logic [CNT_W-1:0] r_outstanding;
  logic             r_buf_full;
  logic [63:0]      r_buf_data;
  logic             r_rf_we;
  logic [5:0]       r_rf_waddr;
  logic [31:0]      r_rf_wdata;
  logic [63:0]      r_rf_prod;
  logic             r_wb_err;

  logic w_live, w_drain, w_blocked, w_capture, w_issue, w_dec;

  assign o_wb_freeze = (r_state == StForce);
  // Address 0 is a discarded write; addresses above 33 are errors, never written.
  assign w_live    = i_wb_regwrite && (i_wb_rd != 6'd0) && (i_wb_rd <= LastReg) && !o_wb_freeze;
  assign w_drain   = r_buf_full && !w_live;
  assign w_blocked = r_buf_full && w_live;
  // A draining buffer can be refilled in the same cycle.
  assign o_md_ready = !r_buf_full || w_drain;
  assign w_capture  = i_md_valid && o_md_ready;

  assign o_md_issue_ready = (r_outstanding < CNT_W'(MAX_OUT));
  assign w_issue          = i_md_issue && o_md_issue_ready;
  assign w_dec            = w_drain && (r_outstanding != '0);
  assign o_hilo_hazard    = i_id_uses_hilo && (r_outstanding != '0);

  assign o_rf_we    = r_rf_we;
  assign o_rf_waddr = r_rf_waddr;
  assign o_rf_wdata = r_rf_wdata;
  assign o_rf_prod  = r_rf_prod;
  assign o_wb_err   = r_wb_err;

  // Starvation FSM next state: count blocked cycles, force a drain at the limit.
  always_comb begin
    w_state_d    = r_state;
    w_starve_d   = r_starve;
    w_starve_inc = (r_state == StIdle) ? StW'(1) : r_starve + StW'(1);
    unique case (r_state)
      StIdle, StHeld: begin
        if (w_blocked) begin
          w_starve_d = w_starve_inc;
          w_state_d  = (w_starve_inc >= StW'(STARVE_LIMIT)) ? StForce : StHeld;
        end else if (r_state == StHeld) begin
          w_state_d  = StIdle;
          w_starve_d = '0;
        end
      end
      StForce: begin
        w_state_d  = StIdle;
        w_starve_d = '0;
      end
      default: begin
        w_state_d  = StIdle;
        w_starve_d = '0;
      end
    endcase
  end

  // FSM state and starve counter registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= StIdle;
      r_starve <= '0;
    end else begin
      r_state  <= w_state_d;
      r_starve <= w_starve_d;
    end
  end

  // One-entry mult/div result buffer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_buf_full <= 1'b0;
      r_buf_data <= '0;
    end else if (w_capture) begin
      r_buf_full <= 1'b1;
      r_buf_data <= i_md_prod;
    end else if (w_drain) begin
      r_buf_full <= 1'b0;
    end
  end

  // In-flight mult/div count; an issue and a drain in one cycle cancel out.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_outstanding <= '0;
    end else if (w_issue && !w_dec) begin
      r_outstanding <= r_outstanding + CNT_W'(1);
    end else if (!w_issue && w_dec) begin
      r_outstanding <= r_outstanding - CNT_W'(1);
    end
  end

  // Registered write port; address and data hold when no write is granted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
      r_rf_prod  <= '0;
      r_wb_err   <= 1'b0;
    end else begin
      r_rf_we <= w_live || w_drain;
      if (w_live) begin
        r_rf_waddr <= i_wb_rd;
        r_rf_wdata <= i_wb_data;
      end else if (w_drain) begin
        r_rf_waddr <= PairAddr;
        r_rf_prod  <= r_buf_data;
      end
      if (i_wb_regwrite && (i_wb_rd > LastReg)) begin
        r_wb_err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Owns the single write port of the 34-entry register file: general registers 0–31, $hi at 32, $lo at 33.
- Arbitrates that port between the pipeline MEM/WB write stream and 64-bit results from the multicycle mult/div unit.
- Mult/div results are held in a one-entry buffer; a starvation FSM forces the buffer to drain.
- Tracks in-flight mult/div operations and raises a hi/lo read hazard toward the decode stage.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles a buffered mult/div result may be blocked before the pipeline WB is frozen.
- MAX_OUT, 2: maximum number of in-flight mult/div operations.
- CNT_W, 2: width of the outstanding counter; must hold MAX_OUT.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low
- wb_regwrite  in  1  pipeline MEM/WB write request
- wb_rd  in  6  pipeline destination register, 0–33
- wb_data  in  32  pipeline write data
- md_issue  in  1  mult/div operation issued from EX this cycle
- md_issue_ready  out  1  high when outstanding < MAX_OUT
- md_valid  in  1  mult/div result valid
- md_prod  in  64  mult/div result, {hi, lo}
- md_ready  out  1  buffer can accept a result
- id_uses_hilo  in  1  decode-stage instruction reads $hi or $lo
- hilo_hazard  out  1  stall decode
- wb_freeze  out  1  pipeline must hold MEM/WB this cycle
- rf_we  out  1  regfile write enable
- rf_waddr  out  6  regfile write address; 34 = {hi, lo} pair write
- rf_wdata  out  32  regfile write data
- rf_prod  out  64  pair write data
- wb_err  out  1  sticky flag: pipeline attempted wb_rd ≥ 34

Behaviour:
- Reset (reset = 0, asynchronous):
  - All registered outputs go to 0: rf_we, rf_waddr, rf_wdata, rf_prod, wb_err, wb_freeze.
  - Buffer is emptied, outstanding = 0, FSM = IDLE.
  - Reset mid-operation discards any buffered result and all in-flight counts.
- rf_* outputs are registered; the regfile sees a write one cycle after the accepted request.
- Pipeline write is "live" when wb_regwrite = 1, wb_rd ≠ 0, wb_rd ≤ 33 and wb_freeze = 0.
  - wb_rd = 0: treated as no write.
  - wb_rd ≥ 34: ignored, sets wb_err, which stays set until reset.
- Buffer accept:
  - md_ready = buffer empty, OR the buffer drains this cycle (pass-through refill).
  - A result is captured when md_valid & md_ready.
- Grant, evaluated each cycle:
  - A live pipeline write always wins: next rf_we = 1, rf_waddr = wb_rd, rf_wdata = wb_data.
  - Otherwise, if the buffer is full, it drains: rf_we = 1, rf_waddr = 34, rf_prod = buffered value; the buffer empties unless refilled the same cycle.
  - Otherwise rf_we = 0; rf_waddr, rf_wdata and rf_prod hold their previous values.
- FSM:
  - IDLE: buffer empty or draining. Go to HELD when the buffer is full and blocked by a live pipeline write; starve counter = 1.
  - HELD: starve counter increments each blocked cycle. Return to IDLE on drain. Go to FORCE when the counter reaches STARVE_LIMIT.
  - FORCE: wb_freeze = 1 for exactly one cycle; the pipeline write is not live, so the buffer drains. Return to IDLE and clear the counter.
  - wb_freeze is combinational from the state; it is high only in FORCE.
- Outstanding counter:
  - +1 on md_issue & md_issue_ready.
  - −1 on each pair drain (rf_we with address 34 committed).
  - Both in the same cycle: counter unchanged.
  - md_issue while outstanding = MAX_OUT is dropped.
- Hazard: hilo_hazard = id_uses_hilo & (outstanding ≠ 0). Combinational.

Test Plan:
- Pipeline writes: reset release, then wb_rd = 5, wb_data = 0xDEADBEEF, wb_regwrite = 1 → next cycle rf_we = 1, rf_waddr = 5, rf_wdata = 0xDEADBEEF. Then wb_rd = 0 → rf_we = 0 next cycle.
- Free-port mult/div path: md_issue = 1, then md_valid = 1 with md_prod = 0x00000001_00000002 and no pipeline write → outstanding goes 1 then 0; next cycle rf_waddr = 34, rf_prod = 0x0000000100000002. hilo_hazard is high while outstanding = 1 and id_uses_hilo = 1.
- Contention: buffered result plus live pipeline writes for 4 consecutive cycles (STARVE_LIMIT = 4) → wb_freeze = 1 in cycle 5. Pair write appears the following cycle; md_ready = 0 while held.
- Simultaneous issue and drain at outstanding = 1 → stays 1. Two issues at MAX_OUT = 2 → md_issue_ready = 0 and the third issue is ignored.
- Illegal address: wb_rd = 34 from the pipeline → no write, wb_err = 1 and sticky.
- Reset mid-operation: assert reset while in HELD with a full buffer → all outputs 0 immediately, buffer empty, outstanding = 0, hilo_hazard = 0.
